// File: rtl/sodor5_lockstep_pkg.sv
// rtl/sodor5_lockstep_pkg.sv - shared types and constants for the Sodor 5-stage lockstep model
package sodor5_lockstep_pkg;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int RW = $clog2(NREGS);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'd0,
        F3_SLL  = 3'd1,
        F3_SLT  = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR  = 3'd4,
        F3_SR   = 3'd5,
        F3_OR   = 3'd6,
        F3_AND  = 3'd7
    } funct3_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        alu_op_e         op;
        logic            use_imm;
        logic [XLEN-1:0] imm;
    } dec_t;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rd;
        alu_op_e         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] result;
    } res_t;

    // OP-IMM has no SUBI, so funct7[5]/imm[10] only matters for shifts there.
    function automatic alu_op_e decode_op(input logic is_imm, input funct3_e f3, input logic alt);
        case (f3)
            F3_ADD:  return (alt && !is_imm) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/sodor5_lockstep_alu.sv
// rtl/sodor5_lockstep_alu.sv - combinational RV32I integer ALU for the lockstep model
module sodor5_lockstep_alu
    import sodor5_lockstep_pkg::*;
(
    input  alu_op_e         i_alu_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        unique case (i_alu_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/sodor5_lockstep_model.sv
// rtl/sodor5_lockstep_model.sv - 5-stage Sodor OP/OP-IMM reference model; SODOR_LOCKSTEP_CHECK_EN enables the commit compare
module sodor5_lockstep_model
    import sodor5_lockstep_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            core_wb_valid,
    input  logic [4:0]      core_wb_rd,
    input  logic [31:0]     core_wb_data,
    output logic            model_wb_valid,
    output logic [4:0]      model_wb_rd,
    output logic [31:0]     model_wb_data,
    output logic            mismatch
);

    logic [XLEN-1:0] regfile [0:NREGS-1];

    logic [31:0]     r_if_id_instr;
    logic            r_if_id_valid;
    id_ex_t          r_id_ex;
    res_t            r_ex_mem;
    res_t            r_mem_wb;

    dec_t            w_dec;
    logic            w_is_op;
    logic            w_is_imm;
    logic [XLEN-1:0] w_ex_result;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_wb_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_instr <= NOP_INSN;
            r_if_id_valid <= 1'b0;
        end else begin
            r_if_id_instr <= instr;
            r_if_id_valid <= 1'b1;
        end
    end

    assign w_is_op  = (r_if_id_instr[6:0] == OPC_OP);
    assign w_is_imm = (r_if_id_instr[6:0] == OPC_OP_IMM);

    always_comb begin
        w_dec         = '0;
        w_dec.valid   = r_if_id_valid && (w_is_op || w_is_imm);
        w_dec.rd      = r_if_id_instr[11:7];
        w_dec.rs1     = r_if_id_instr[19:15];
        w_dec.rs2     = r_if_id_instr[24:20];
        w_dec.use_imm = w_is_imm;
        w_dec.imm     = {{(XLEN-12){r_if_id_instr[31]}}, r_if_id_instr[31:20]};
        w_dec.op      = decode_op(w_is_imm, funct3_e'(r_if_id_instr[14:12]), r_if_id_instr[30]);
    end

    // The EX/MEM path is the ALU output about to enter EX/MEM, so a back-to-back
    // consumer sees its producer; the MEM/WB entry also covers the same-cycle write.
    function automatic logic [XLEN-1:0] read_src(
        input logic [RW-1:0]   rs,
        input id_ex_t          ex,
        input logic [XLEN-1:0] ex_res,
        input res_t            mem,
        input res_t            wb,
        input logic [XLEN-1:0] rf_val
    );
        if (rs == '0)                      return '0;
        if (ex.valid  && (ex.rd  == rs))   return ex_res;
        if (mem.valid && (mem.rd == rs))   return mem.result;
        if (wb.valid  && (wb.rd  == rs))   return wb.result;
        return rf_val;
    endfunction

    always_comb begin
        w_rs1_val = read_src(w_dec.rs1, r_id_ex, w_ex_result, r_ex_mem, r_mem_wb, regfile[w_dec.rs1]);
        w_rs2_val = read_src(w_dec.rs2, r_id_ex, w_ex_result, r_ex_mem, r_mem_wb, regfile[w_dec.rs2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_ex  <= '0;
            r_ex_mem <= '0;
            r_mem_wb <= '0;
        end else begin
            r_id_ex.valid    <= w_dec.valid;
            r_id_ex.rd       <= w_dec.rd;
            r_id_ex.op       <= w_dec.op;
            r_id_ex.a        <= w_rs1_val;
            r_id_ex.b        <= w_dec.use_imm ? w_dec.imm : w_rs2_val;
            r_ex_mem.valid   <= r_id_ex.valid;
            r_ex_mem.rd      <= r_id_ex.rd;
            r_ex_mem.result  <= w_ex_result;
            r_mem_wb         <= r_ex_mem;
        end
    end

    sodor5_lockstep_alu u_alu (
        .i_alu_op (r_id_ex.op),
        .i_a      (r_id_ex.a),
        .i_b      (r_id_ex.b),
        .o_result (w_ex_result)
    );

    assign w_wb_valid = r_mem_wb.valid && (r_mem_wb.rd != '0);

    always_ff @(posedge clk) begin
        if (!reset && w_wb_valid) begin
            regfile[r_mem_wb.rd] <= r_mem_wb.result;
        end
    end

    assign model_wb_valid = w_wb_valid;
    assign model_wb_rd    = w_wb_valid ? r_mem_wb.rd : '0;
    assign model_wb_data  = w_wb_valid ? r_mem_wb.result : '0;

`ifdef SODOR_LOCKSTEP_CHECK_EN
    logic r_mismatch;
    logic w_diverge;

    assign w_diverge = (core_wb_valid != model_wb_valid) ||
                       (core_wb_valid && model_wb_valid &&
                        ((core_wb_rd != model_wb_rd) || (core_wb_data != model_wb_data)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_diverge) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_core;
    assign w_unused_core = ^{core_wb_valid, core_wb_rd, core_wb_data};
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sodor5_lockstep_model.sv
// tb/tb_sodor5_lockstep_model.sv - scoreboard bench for the Sodor 5-stage lockstep model
module tb_sodor5_lockstep_model;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        core_wb_valid;
    logic [4:0]  core_wb_rd;
    logic [31:0] core_wb_data;
    logic        model_wb_valid;
    logic [4:0]  model_wb_rd;
    logic [31:0] model_wb_data;
    logic        mismatch;

    sodor5_lockstep_model dut (
        .clk            (clk),
        .reset          (reset),
        .instr          (instr),
        .core_wb_valid  (core_wb_valid),
        .core_wb_rd     (core_wb_rd),
        .core_wb_data   (core_wb_data),
        .model_wb_valid (model_wb_valid),
        .model_wb_rd    (model_wb_rd),
        .model_wb_data  (model_wb_data),
        .mismatch       (mismatch)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_rf [32];
    bit          exp_mm;
    bit          inj;
    int          n_assert;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Sequential architectural reference: executes each instruction at issue time.
    task automatic ref_exec(input logic [31:0] ins, output exp_t e);
        logic        is_op, is_imm;
        logic [31:0] a, b, r;
        logic [4:0]  rd, sh;
        is_op  = (ins[6:0] == 7'b0110011);
        is_imm = (ins[6:0] == 7'b0010011);
        rd     = ins[11:7];
        a      = (ins[19:15] == 0) ? 32'h0 : m_rf[ins[19:15]];
        b      = is_op ? ((ins[24:20] == 0) ? 32'h0 : m_rf[ins[24:20]])
                       : {{20{ins[31]}}, ins[31:20]};
        sh     = b[4:0];
        case (ins[14:12])
            3'd0: r = (is_op && ins[30]) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        e.v  = (is_op || is_imm) && (rd != 0);
        e.rd = e.v ? rd : 5'd0;
        e.d  = e.v ? r : 32'd0;
        if (e.v) m_rf[rd] = r;
    endtask

    task automatic step(input logic [31:0] ins);
        exp_t e, p;
        instr = ins;
        ref_exec(ins, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (inj) begin
`ifdef SODOR_LOCKSTEP_CHECK_EN
            exp_mm = 1'b1;
`endif
            inj = 1'b0;
        end
        check("mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
        if (sb_q.size() == 4) begin
            p = sb_q.pop_front();
            check("wb_valid", {31'd0, model_wb_valid}, {31'd0, p.v});
            if (p.v) begin
                check("wb_rd", {27'd0, model_wb_rd}, {27'd0, p.rd});
                check("wb_data", model_wb_data, p.d);
            end
            core_wb_valid = p.v;
            core_wb_rd    = p.rd;
            core_wb_data  = p.d;
        end
    endtask

    task automatic drain();
        repeat (5) step(NOP);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        dut.regfile[idx] = val;
        m_rf[idx] = val;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        instr = 32'hDEAD_BEEF;
        repeat (n) @(posedge clk);
        #1;
        sb_q.delete();
        exp_mm        = 1'b0;
        inj           = 1'b0;
        core_wb_valid = 1'b0;
        core_wb_rd    = 5'd0;
        core_wb_data  = 32'd0;
        check("rst_wb_valid", {31'd0, model_wb_valid}, 32'd0);
        check("rst_wb_rd", {27'd0, model_wb_rd}, 32'd0);
        check("rst_wb_data", model_wb_data, 32'd0);
        check("rst_mismatch", {31'd0, mismatch}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_mm   = 1'b0;
        inj      = 1'b0;
        reset    = 1'b1;
        instr    = NOP;
        core_wb_valid = 1'b0;
        core_wb_rd    = 5'd0;
        core_wb_data  = 32'd0;
        for (int i = 0; i < 32; i++) preload(i, 32'd0);
        do_reset(3);

        // Basic add with writeback latency and regfile write one edge later
        preload(1, 32'd5);
        preload(2, 32'd7);
        step(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        repeat (3) step(NOP);
        step(NOP);
        check("rf_x3", dut.regfile[3], 32'd12);

        // Dependent sub at distances 1..4 covers every forwarding source
        for (int gap = 0; gap < 4; gap++) begin
            drain();
            preload(3, 32'd0);
            preload(4, 32'd0);
            step(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
            repeat (gap) step(NOP);
            step(rtype(7'h20, 5'd1, 5'd3, 3'd0, 5'd4));
            drain();
            check("rf_x4_fwd", dut.regfile[4], 32'd7);
        end

        // Shifts
        preload(5, 32'h8000_0000);
        preload(1, 32'd1);
        step(itype(12'h404, 5'd5, 3'd5, 5'd6));
        step(itype(12'h004, 5'd5, 3'd5, 5'd6));
        step(rtype(7'h00, 5'd1, 5'd5, 3'd1, 5'd6));
        drain();

        // Signed vs unsigned compare
        preload(1, 32'hFFFF_FFFF);
        preload(2, 32'd1);
        step(rtype(7'h00, 5'd2, 5'd1, 3'd2, 5'd7));
        step(rtype(7'h00, 5'd2, 5'd1, 3'd3, 5'd7));
        drain();

        // x0 destination and unsupported opcode are bubbles
        step(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
        step(32'h0000_0003);
        drain();
        check("rf_x0", dut.regfile[0], 32'd0);

        // Random back-to-back mix over a small register window
        for (int i = 1; i < 8; i++) preload(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [4:0]  rd, rs1, rs2;
            logic        alt;
            logic [11:0] imm;
            f3  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            alt = 1'($urandom_range(0, 1));
            imm = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                step(rtype(((f3 == 3'd0) || (f3 == 3'd5)) && alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd));
            end else begin
                if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
                if (f3 == 3'd5) imm = {1'b0, alt, 5'd0, imm[4:0]};
                step(itype(imm, rs1, f3, rd));
            end
        end
        drain();
        for (int i = 1; i < 8; i++) check("rf_rand", dut.regfile[i], m_rf[i]);

        // Divergence injection on a valid commit
        preload(1, 32'd5);
        preload(2, 32'd7);
        step(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        repeat (3) step(NOP);
        core_wb_data = core_wb_data ^ 32'd1;
        inj = 1'b1;
        repeat (4) step(NOP);

        // Reset with instructions in flight: none of them may reach the regfile
        preload(9, 32'h55);
        for (int i = 0; i < 4; i++) begin
            instr = itype(12'h123, 5'd0, 3'd0, 5'd9);
            @(posedge clk);
        end
        do_reset(2);
        check("rst_rf_x9", dut.regfile[9], 32'h55);
        drain();
        check("post_rst_rf_x9", dut.regfile[9], 32'h55);
        step(itype(12'h7FF, 5'd9, 3'd0, 5'd10));
        drain();
        check("post_rst_rf_x10", dut.regfile[10], 32'h854);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
